// File: rtl/tx_frame_buffer.sv
// tx_frame_buffer: byte FIFO tagged with end-of-frame that replays whole frames
// (or cut-through) to an AXI-Stream MAC port through a registered holding stage.
module tx_frame_buffer #(
   parameter int DEPTH        = 2048,
   parameter int AFULL_MARGIN = 4,
   parameter int STORE_FWD    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   input  logic [15:0] number_of_bytes,
   output logic        btx_full,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   output logic        overflow,
   output logic        len_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {WR_IDLE, WR_BODY} wr_t;
   typedef enum logic {RD_IDLE, RD_STREAM} rd_t;

   wr_t wr_state, wr_next;
   rd_t rd_state, rd_next;
   logic [8:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] cnt, fcnt;
   logic [15:0] len, wcnt;
   logic [7:0] hdata;
   logic hvalid, hlast, wr_last, push, pop, hs, start;

   always_comb begin
      wr_last = tx_valid && (wr_state == WR_IDLE ? number_of_bytes <= 16'd1 : wcnt == len - 16'd1);
      wr_next = !tx_valid ? wr_state : (wr_last ? WR_IDLE : WR_BODY);
      hs      = hvalid && m_axis_tready;
      // never pull the next frame's byte in behind a pending tlast
      pop     = rd_state == RD_STREAM && (!hvalid || hs) && !(hvalid && hlast) && cnt != '0;
      push    = tx_valid && (cnt != CW'(DEPTH) || pop);
      start   = STORE_FWD != 0 ? fcnt != '0 : cnt != '0;
      rd_next = rd_state == RD_IDLE ? (start ? RD_STREAM : RD_IDLE) : (hs && hlast ? RD_IDLE : RD_STREAM);
   end

   always_ff @(posedge clk)
      if (push) mem[wptr] <= {wr_last, tx_data};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_state <= WR_IDLE;
         rd_state <= RD_IDLE;
         len      <= '0;
         wcnt     <= '0;
         wptr     <= '0;
         rptr     <= '0;
         cnt      <= '0;
         fcnt     <= '0;
         hvalid   <= 1'b0;
         hdata    <= '0;
         hlast    <= 1'b0;
         btx_full <= 1'b0;
         overflow <= 1'b0;
         len_err  <= 1'b0;
      end else begin
         wr_state <= wr_next;
         rd_state <= rd_next;
         if (tx_valid && wr_state == WR_IDLE) len <= number_of_bytes;
         if (tx_valid) wcnt <= wr_state == WR_IDLE ? 16'd1 : wcnt + 16'd1;
         wptr     <= wptr + AW'(push);
         rptr     <= rptr + AW'(pop);
         cnt      <= cnt + CW'(push) - CW'(pop);
         fcnt     <= fcnt + CW'(push && wr_last) - CW'(hs && hlast);
         hvalid   <= pop || (hvalid && !hs);
         if (pop) {hlast, hdata} <= mem[rptr];
         btx_full <= cnt >= CW'(DEPTH - AFULL_MARGIN);
         overflow <= overflow || (tx_valid && !push);
         len_err  <= tx_valid && wr_state == WR_IDLE && number_of_bytes == 16'd0;
      end

   assign m_axis_tdata  = hdata;
   assign m_axis_tvalid = hvalid;
   assign m_axis_tlast  = hlast;
endmodule

// File: tb/tb_tx_frame_buffer.sv
// tb_tx_frame_buffer: directed frames; expected beats queued by stimulus, checked by a monitor.
module tb_tx_frame_buffer;
   logic clk = 1'b0, rst_n = 1'b0, tx_valid = 1'b0, m_axis_tready = 1'b0;
   logic [7:0] tx_data = '0;
   logic [15:0] number_of_bytes = '0;
   logic btx_full, m_axis_tvalid, m_axis_tlast, overflow, len_err;
   logic [7:0] m_axis_tdata;
   logic [8:0] exp_q[$];
   int checks = 0, passes = 0;
   logic prev_stall = 1'b0, prev_last;
   logic [7:0] prev_data;

   tx_frame_buffer dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .number_of_bytes(number_of_bytes), .btx_full(btx_full), .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .overflow(overflow), .len_err(len_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, got, want);
   endtask

   always @(negedge clk)
      if (!rst_n) prev_stall <= 1'b0;
      else begin
         if (prev_stall) begin
            check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("stall_tdata", 32'(m_axis_tdata), 32'(prev_data));
            check("stall_tlast", 32'(m_axis_tlast), 32'(prev_last));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) check("unexpected_beat", {23'd0, m_axis_tlast, m_axis_tdata}, 32'h1ff);
            else check("beat", {23'd0, m_axis_tlast, m_axis_tdata}, 32'(exp_q.pop_front()));
         end
         prev_stall <= m_axis_tvalid && !m_axis_tready;
         prev_data  <= m_axis_tdata;
         prev_last  <= m_axis_tlast;
      end

   task automatic send_byte(input logic [7:0] d, input logic [15:0] nob);
      tx_valid = 1'b1;
      tx_data = d;
      number_of_bytes = nob;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic send_frame(input int n, input logic [15:0] nob, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({i == n - 1, base + 8'(i)});
         send_byte(base + 8'(i), i == 0 ? nob : 16'hBEEF);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      check("rst_outputs", {26'd0, btx_full, m_axis_tvalid, m_axis_tlast, overflow, len_err, |m_axis_tdata}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_axis_tready = 1'b1;
      // 5-byte frame with two-cycle start latency after the last write
      send_frame(5, 16'd5, 8'h01);
      check("t1_lat0", 32'(m_axis_tvalid), 32'd0);
      @(posedge clk);
      #1 check("t1_lat1", 32'(m_axis_tvalid), 32'd0);
      @(posedge clk);
      #1 check("t1_lat2", 32'(m_axis_tvalid), 32'd1);
      drain();
      // 64-byte frame under alternating tready
      fork
         send_frame(64, 16'd64, 8'h40);
         repeat (220) begin
            @(posedge clk);
            #1 m_axis_tready = ~m_axis_tready;
         end
      join
      m_axis_tready = 1'b1;
      drain();
      // zero length becomes a single-byte frame
      send_frame(1, 16'd0, 8'hAA);
      check("t4_len_err_hi", 32'(len_err), 32'd1);
      @(posedge clk);
      #1 check("t4_len_err_lo", 32'(len_err), 32'd0);
      drain();
      // three back-to-back frames held, then released
      m_axis_tready = 1'b0;
      send_frame(1, 16'd1, 8'h10);
      send_frame(2, 16'd2, 8'h20);
      send_frame(3, 16'd3, 8'h30);
      repeat (3) @(posedge clk);
      #1 check("t5_fcnt", 32'(dut.fcnt), 32'd3);
      m_axis_tready = 1'b1;
      drain();
      // fill to full with an unfinished frame
      m_axis_tready = 1'b0;
      for (int i = 0; i < 2049; i++) begin
         send_byte(8'(i), i == 0 ? 16'd3000 : 16'd7);
         if (i == 2043) check("t3_afull_lo", 32'(btx_full), 32'd0);
         if (i == 2044) check("t3_afull_hi", 32'(btx_full), 32'd1);
         if (i == 2047) check("t3_ovf_lo", 32'(overflow), 32'd0);
         if (i == 2048) check("t3_ovf_hi", 32'(overflow), 32'd1);
      end
      check("t3_tvalid", 32'(m_axis_tvalid), 32'd0);
      // asynchronous reset in the middle of a frame
      for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 16'd10);
      #3 rst_n = 1'b0;
      #1 check("t6_async", {28'd0, btx_full, overflow, m_axis_tvalid, len_err}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_axis_tready = 1'b1;
      send_frame(2, 16'd2, 8'h11);
      drain();
      check("final_overflow", 32'(overflow), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
